ram_delay_line_ctrl: RTL
========================

// Module: ram_delay_line_ctrl
// PURPOSE
//  Upstream controller for the single-port, negedge-clocked RAM1 sample store (karaoke echo/delay path).
//  Accepts audio samples over valid/ready and writes each one into RAM1 as a circular buffer.
//  For each sample it reads the sample written cfg_delay samples earlier and presents it downstream.
//  Owns all RAM1 ports: wEn, addr, dataIn and dataOut.
// PARAMETERS
//  DATA_WIDTH     32  sample width, two's-complement signed
//  ADDRESS_WIDTH  12  RAM address width
//  DEPTH          4096  RAM words; must equal 2**ADDRESS_WIDTH
//  ECHO_SHIFT     1   attenuation of the delayed sample in mix mode (arithmetic right shift)
// PORTS
//  clk          in   1      system clock; all block state is updated on posedge
//  reset_n      in   1      asynchronous, active-low reset
//  in_valid     in   1      upstream sample valid
//  in_ready     out  1      block can accept a sample (high only in IDLE)
//  in_data      in   DW     input sample
//  cfg_delay    in   AW     delay in samples, 0..DEPTH-1; latched when a sample is accepted
//  out_valid    out  1      delayed sample valid
//  out_ready    in   1      downstream accepts
//  out_data     out  DW     delayed (or mixed) sample
//  ram_wEn      out  1      RAM1 write enable
//  ram_addr     out  AW     RAM1 address
//  ram_dataIn   out  DW     RAM1 write data
//  ram_dataOut  in   DW     RAM1 read data; updated on the negedge of every non-write cycle
// BEHAVIOUR
//  Reset values: in_ready=0, out_valid=0, out_data=0, ram_wEn=0, ram_addr=0, ram_dataIn=0.
//  Reset also clears wr_ptr=0, fill=0 and state=IDLE. RAM contents are never cleared.
//  in_ready rises on the first clk after reset_n deasserts.
//  FSM: IDLE -> RD -> WR -> OUT -> IDLE.
//  IDLE: in_ready=1. On in_valid, latch in_data and cfg_delay (dly), then go to RD.
//  RD: ram_addr = wr_ptr - dly (mod DEPTH), ram_wEn=0.
//   - RAM1 samples this on the negedge inside RD.
//   - Capture ram_dataOut into rd_q on the posedge that leaves RD.
//  WR: ram_wEn=1, ram_addr=wr_ptr, ram_dataIn=held sample.
//   - On exit: wr_ptr+1 (wraps DEPTH-1 -> 0); fill = min(fill+1, DEPTH-1).
//  OUT: out_valid=1. out_data is held stable until out_ready; in_ready stays 0.
//   - On out_valid & out_ready, go to IDLE.
//  Delayed value: if dly==0 -> the held input sample (bypass); RD still runs, read data is ignored.
//   - Else if fill < dly -> 0 (masks stale RAM after reset).
//   - Else -> rd_q.
//  RAM ports are decoded from registered state/pointers and are stable well before each negedge.
//  In IDLE and OUT: ram_wEn=0, ram_addr=wr_ptr.
//  Throughput: 1 sample per 4 clks minimum; latency from in accept to out_valid is 3 clks.
//  cfg_delay changes while a sample is in flight have no effect until the next accept.
//  Reset mid-operation: immediate return to reset values. A partially written sample is lost; no RAM write occurs after assertion.
// CONFIGURATION
//  DELAY_ECHO_MIX_EN defined:
//   out_data = sat(held_in + (delayed >>> ECHO_SHIFT)), signed, clamped to [-2^(DW-1), 2^(DW-1)-1].
//  Not defined: out_data = delayed value; no adder is instantiated.
// STRUCTURE
//  delay_line_pkg: state enum {IDLE,RD,WR,OUT}, and DW/AW/DEPTH defaults as localparams.
//  Sub-module sat_add (signed saturating adder, DATA_WIDTH param); instantiated only under DELAY_ECHO_MIX_EN.
// TESTING (bench includes a RAM1 model on negedge)
//  1. cfg_delay=0, samples 5,6,7 -> outputs 5,6,7, each 3 clks after accept.
//  2. cfg_delay=3, samples 1..6 -> outputs 0,0,0,1,2,3.
//  3. out_ready low 10 clks in OUT -> out_data stable, in_ready=0, no ram_wEn pulses.
//  4. DEPTH=16, AW=4, delay=15, samples 1..40 -> wr_ptr wraps; output n equals sample n-15.
//     Outputs 1..15 are 0.
//  5. Pulse reset_n low during WR -> no write lands; outputs reset.
//     Then delay=2, samples 9,9,9 -> outputs 0,0,9, with stale RAM masked.
//  6. MIX_EN, ECHO_SHIFT=1, delay=1, samples 0x7FFFFFF0 twice -> second output is 0x7FFFFFFF (saturated).

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared types and default sizes for the RAM1 delay-line controller.
package delay_line_pkg;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 12;
    localparam int DEPTH_DEF = 4096;

    typedef enum logic [1:0] {IDLE, RD, WR, OUT} state_t;

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder; clamps to the representable two's-complement range.
module sat_add #(
    parameter int DATA_WIDTH = 32
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] y
);

    localparam int DW = DATA_WIDTH;

    logic signed [DW:0] sum;

    assign sum = {a[DW-1], a} + {b[DW-1], b};

    // Overflow shows up as disagreement between the extra sign bit and the MSB.
    always_comb begin
        y = sum[DW-1:0];
        if (sum[DW] != sum[DW-1])
            y = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end

endmodule

// File: rtl/ram_delay_line_ctrl.sv
// Circular-buffer controller for the negedge RAM1 sample store: write each sample, return the one cfg_delay back.
// Define DELAY_ECHO_MIX_EN to output sat(input + delayed >>> ECHO_SHIFT) instead of the raw delayed sample.
module ram_delay_line_ctrl
    import delay_line_pkg::*;
#(
    parameter int DATA_WIDTH    = DW_DEF,
    parameter int ADDRESS_WIDTH = AW_DEF,
    parameter int DEPTH         = DEPTH_DEF,
    parameter int ECHO_SHIFT    = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [ADDRESS_WIDTH-1:0] cfg_delay,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDRESS_WIDTH;

    if (DEPTH != (1 << ADDRESS_WIDTH) || ECHO_SHIFT < 0 || ECHO_SHIFT >= DATA_WIDTH) begin : g_bad_cfg
        $error("ram_delay_line_ctrl: DEPTH must be 2**ADDRESS_WIDTH and ECHO_SHIFT < DATA_WIDTH");
    end

    state_t        state;
    logic [AW-1:0] wr_ptr, fill, dly;
    logic [DW-1:0] held, rd_q;
    logic [DW-1:0] delayed, mixed;
    logic [AW-1:0] wr_ptr_nx, fill_nx;

    // Pointer wraps for free because DEPTH is a power of two.
    assign wr_ptr_nx = wr_ptr + 1'b1;
    assign fill_nx   = (fill == AW'(DEPTH - 1)) ? fill : fill + 1'b1;

    // fill counts samples written since reset, so reads beyond it would return stale RAM.
    always_comb begin
        delayed = rd_q;
        if (dly == '0)
            delayed = held;
        else if (fill < dly)
            delayed = '0;
    end

`ifdef DELAY_ECHO_MIX_EN
    logic signed [DW-1:0] echo;

    assign echo = $signed(delayed) >>> ECHO_SHIFT;

    sat_add #(.DATA_WIDTH(DW)) u_mix (
        .a (held),
        .b (echo),
        .y (mixed)
    );
`else
    assign mixed = delayed;
`endif

    // RAM ports are registered so they settle a half cycle before RAM1's negedge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            fill       <= '0;
            dly        <= '0;
            held       <= '0;
            rd_q       <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            ram_wEn    <= 1'b0;
            ram_addr   <= '0;
            ram_dataIn <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready && in_valid) begin
                        held     <= in_data;
                        dly      <= cfg_delay;
                        in_ready <= 1'b0;
                        ram_wEn  <= 1'b0;
                        ram_addr <= wr_ptr - cfg_delay;
                        state    <= RD;
                    end else begin
                        in_ready <= 1'b1;
                        ram_addr <= wr_ptr;
                    end
                end
                RD: begin
                    rd_q       <= ram_dataOut;
                    ram_wEn    <= 1'b1;
                    ram_addr   <= wr_ptr;
                    ram_dataIn <= held;
                    state      <= WR;
                end
                WR: begin
                    wr_ptr    <= wr_ptr_nx;
                    fill      <= fill_nx;
                    ram_wEn   <= 1'b0;
                    ram_addr  <= wr_ptr_nx;
                    out_valid <= 1'b1;
                    out_data  <= mixed;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
